csa_pipe_addsub: RTL
====================

# csa_pipe_addsub

Parametrised, pipelined carry-select adder/subtractor for the processor datapath ALU and address path. Operands are split into BLOCK-bit carry-select blocks; the word is divided across STAGES pipeline stages, with the inter-stage carry registered. A valid/ready handshake with full backpressure lets the ALU stall it. It also reports carry-out, signed overflow and zero.

## Interface
- WIDTH, 32: operand/result width. Must be a multiple of STAGES*BLOCK.
- BLOCK, 8: carry-select block width in bits.
- STAGES, 2: pipeline stages; each stage handles WIDTH/STAGES bits. Range 1..WIDTH/BLOCK.

- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- op_a  in  WIDTH  operand A.
- op_b  in  WIDTH  operand B.
- sub  in  1  1 = A−B; 0 = A+B.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  sum/difference, mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH−1 (for subtract: 1 = no borrow).
- ovf  out  1  two's-complement signed overflow.
- zero  out  1  result == 0.

## Operation
- Subtract is A + ~B + 1: B is inverted and carry-in = sub at stage 0. The sub flag travels with the data.
- Within a stage, each BLOCK-bit block computes two sums, one for carry-in 0 and one for carry-in 1. The real carry selects between them.
  - Block 0 of stage 0 uses the real carry-in directly.
- Stage s computes bits [s*W/S +: W/S] from registered operand slices and the registered carry out of stage s−1.
  - Already-computed lower result slices and the unprocessed upper operand slices are carried forward in that stage's register.
- Final stage:
  - cout = carry out of MSB.
  - ovf = (a_msb == b'_msb) && (res_msb != a_msb), where b' = B after the sub inversion.
  - zero = ~|result.
  - The result, cout, ovf and zero registers load together.
- Each stage k has a valid bit v[k]. The output register is the last stage, so out_valid = v[STAGES−1].
- Global advance: adv = !out_valid || out_ready.
  - On adv, every stage loads from its predecessor and v[k] <= v[k−1].
  - On adv, v[0] <= in_valid.
- in_ready = adv, which is combinational from out_valid and out_ready.
- Bubbles propagate and are not compressed. A transaction is accepted iff in_valid && in_ready.
- When !adv, all stage registers and valid bits hold, and the outputs stay stable.

## Timing
- Reset, checked at the clock edge:
  - all v[k] = 0, so out_valid = 0 and in_ready = 1;
  - result = 0, cout = 0, ovf = 0, zero = 0 (zero is reset 0 and not recomputed).
- Latency: accepted at edge n → out_valid = 1 with a correct result after edge n+STAGES−1. STAGES=1 is fully registered at 1 cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: out_valid=1, out_ready=0 → in_ready=0. Nothing advances. Data is never dropped or duplicated.
- Simultaneous accept and drain: out_valid=1, out_ready=1, in_valid=1 → both occur in the same cycle.
- Reset mid-operation: reset wins over the handshake. All in-flight operations are discarded, and the next cycle presents the reset values.
- Data outputs while out_valid=0 are don't-care, except immediately after reset.
- Critical path per stage: BLOCK-bit ripple plus (WIDTH/STAGES/BLOCK) mux levels.

## Test plan
- Reset with in_valid=1 asserted → out_valid=0, in_ready=1, result=0 for all reset cycles. First accept after reset deasserts.
- WIDTH=32, STAGES=2, add 0x7FFFFFFF + 0x00000001 → after 2 cycles: result=0x80000000, cout=0, ovf=1, zero=0.
- Subtract 0x00000005 − 0x00000005 → result=0, cout=1, ovf=0, zero=1.
  - Subtract 0x00000000 − 0x00000001 → 0xFFFFFFFF, cout=0, ovf=0.
- Back-to-back stream of 100 random add/sub ops with out_ready=1 → one result per cycle, in order, matching a reference model.
  - Repeat with out_ready randomly toggled: no loss or duplication, and outputs stay stable while stalled.
- Carry crossing a stage boundary: 0x0000FFFF + 0x00000001 → 0x00010000. Also 0xFFFFFFFF + 1 → result 0, cout=1, zero=1.
- Reset asserted with 2 ops in flight → neither op appears. A new op after reset completes with the normal latency.
- Re-run the random test with the parameter sets (WIDTH=16, BLOCK=4, STAGES=4) and (WIDTH=64, BLOCK=8, STAGES=1) → latency equals STAGES, and results match the model.

Source files
------------

// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-select adder/subtractor with valid/ready backpressure.
// Each stage adds one WIDTH/STAGES slice; the last stage register is the output register.
module csa_pipe_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned SW = WIDTH / STAGES;
  localparam int unsigned NB = SW / BLOCK;

  // Carry-select add of one stage slice; returns {carry_out, sum}.
  function automatic logic [SW:0] csel_add(input logic [SW-1:0] a,
                                           input logic [SW-1:0] b,
                                           input logic          cin);
    logic [SW-1:0] s;
    logic          c;
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;
    s = '0;
    c = cin;
    for (int unsigned j = 0; j < NB; j++) begin
      if (j == 0) begin
        // lowest block ripples with the real carry-in
        {c, s[j*BLOCK +: BLOCK]} = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]}
                                   + {{BLOCK{1'b0}}, c};
      end else begin
        s0 = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]};
        s1 = {1'b0, a[j*BLOCK +: BLOCK]} + {1'b0, b[j*BLOCK +: BLOCK]} + {{BLOCK{1'b0}}, 1'b1};
        {c, s[j*BLOCK +: BLOCK]} = c ? s1 : s0;
      end
    end
    return {c, s};
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // st_*[k] are the inputs seen by stage k (ports for k=0, previous register otherwise)
  wire [WIDTH-1:0] st_a [STAGES];
  wire [WIDTH-1:0] st_b [STAGES];
  wire [WIDTH-1:0] st_r [STAGES];
  wire             st_c [STAGES];
  wire             st_v [STAGES];

  assign st_a[0] = op_a;
  assign st_b[0] = op_b ^ {WIDTH{sub}};
  assign st_c[0] = sub;
  assign st_r[0] = '0;
  assign st_v[0] = in_valid;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SW:0]      sum_c;
    logic [WIDTH-1:0] r_nxt;

    assign sum_c = csel_add(st_a[k][k*SW +: SW], st_b[k][k*SW +: SW], st_c[k]);

    always_comb begin
      r_nxt = st_r[k];
      r_nxt[k*SW +: SW] = sum_c[SW-1:0];
    end

    if (k + 1 < STAGES) begin : g_mid
      logic             v_q;
      logic             c_q;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] r_q;

      always_ff @(posedge clock) begin
        if (reset) begin
          v_q <= 1'b0;
          c_q <= 1'b0;
          a_q <= '0;
          b_q <= '0;
          r_q <= '0;
        end else if (adv) begin
          v_q <= st_v[k];
          c_q <= sum_c[SW];
          a_q <= st_a[k];
          b_q <= st_b[k];
          r_q <= r_nxt;
        end
      end

      assign st_v[k+1] = v_q;
      assign st_c[k+1] = c_q;
      assign st_a[k+1] = a_q;
      assign st_b[k+1] = b_q;
      assign st_r[k+1] = r_q;
    end else begin : g_last
      // result, flags and valid load together; zero is only computed on a load
      always_ff @(posedge clock) begin
        if (reset) begin
          out_valid <= 1'b0;
          result    <= '0;
          cout      <= 1'b0;
          ovf       <= 1'b0;
          zero      <= 1'b0;
        end else if (adv) begin
          out_valid <= st_v[k];
          result    <= r_nxt;
          cout      <= sum_c[SW];
          ovf       <= (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) &&
                       (r_nxt[WIDTH-1] != st_a[k][WIDTH-1]);
          zero      <= ~|r_nxt;
        end
      end
    end
  end

endmodule
